// File: rtl/boot_loader.sv
// Program-load front end: takes a counted big-endian byte stream, writes it into
// byte-addressed RAM from BASE_ADDR, then releases the control unit's reset.
module boot_loader #(
    parameter int ADDR_WIDTH     = 9,
    parameter int BASE_ADDR      = 0,
    parameter int MAX_WORDS      = 128,
    parameter int RELEASE_CYCLES = 2
) (
    input  logic                  Clk,
    input  logic                  RESET_n,
    input  logic                  start,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_data,
    output logic                  mem_we,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           words_loaded
);

    typedef enum logic [2:0] {
        IDLE, HDR_HI, HDR_LO, DATA, RELEASE, DONE, ERR
    } state_t;

    localparam int RC_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RELEASE_CYCLES - 1);

    state_t                  state, state_nxt;
    logic [7:0]              hdr_hi;
    logic [17:0]             bytes_left;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [1:0]              byte_ofs;
    logic [RC_W-1:0]         rel_cnt;
    logic                    xfer;
    logic [15:0]             hdr_count;

    assign xfer      = byte_valid & byte_ready;
    assign hdr_count = {hdr_hi, byte_in};

    // All status outputs decode directly from the state register.
    assign byte_ready = (state == HDR_HI) || (state == HDR_LO) || (state == DATA);
    assign cpu_reset  = (state != DONE);
    assign done       = (state == DONE);
    assign error      = (state == ERR);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERR: if (start) state_nxt = HDR_HI;
            HDR_HI:          if (xfer) state_nxt = HDR_LO;
            HDR_LO: begin
                if (xfer) begin
                    if (hdr_count == 16'd0)                 state_nxt = RELEASE;
                    else if (hdr_count > 16'(MAX_WORDS))    state_nxt = ERR;
                    else                                    state_nxt = DATA;
                end
            end
            DATA:            if (xfer && bytes_left == 18'd1) state_nxt = RELEASE;
            // The release window only starts counting once the trailing write has retired.
            RELEASE:         if (!mem_we && rel_cnt == RC_LAST) state_nxt = DONE;
            default:         state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge RESET_n) begin
        if (!RESET_n) begin
            state        <= IDLE;
            hdr_hi       <= '0;
            bytes_left   <= '0;
            addr         <= '0;
            byte_ofs     <= '0;
            rel_cnt      <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_data     <= '0;
            words_loaded <= '0;
        end else begin
            state  <= state_nxt;
            mem_we <= 1'b0;
            if (state_nxt == HDR_HI && state != HDR_HI)
                words_loaded <= '0;
            case (state)
                HDR_HI: if (xfer) hdr_hi <= byte_in;
                HDR_LO: begin
                    if (xfer) begin
                        bytes_left <= {hdr_count, 2'b00};
                        addr       <= ADDR_WIDTH'(BASE_ADDR);
                        byte_ofs   <= '0;
                        rel_cnt    <= '0;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        mem_we     <= 1'b1;
                        mem_addr   <= addr;
                        mem_data   <= byte_in;
                        addr       <= addr + 1'b1;
                        bytes_left <= bytes_left - 18'd1;
                        byte_ofs   <= byte_ofs + 2'd1;
                        if (byte_ofs == 2'd3)
                            words_loaded <= words_loaded + 16'd1;
                    end
                end
                RELEASE: if (!mem_we) rel_cnt <= rel_cnt + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboarded bench for boot_loader: expected RAM writes are queued as bytes are
// driven and retired by a monitor watching mem_we.
module tb_boot_loader;
    localparam int AW = 9;

    logic          Clk = 1'b0, RESET_n = 1'b0, start = 1'b0, byte_valid = 1'b0;
    logic [7:0]    byte_in = 8'h00;
    logic          byte_ready, mem_we, cpu_reset, done, error;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic [15:0]   words_loaded;

    boot_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(0), .MAX_WORDS(128), .RELEASE_CYCLES(2)) dut (
        .Clk(Clk), .RESET_n(RESET_n), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_we(mem_we), .cpu_reset(cpu_reset), .done(done),
        .error(error), .words_loaded(words_loaded)
    );

    always #5 Clk = ~Clk;

    typedef struct packed { logic [AW-1:0] addr; logic [7:0] data; } wr_t;

    int         checks = 0, errors = 0, nwrites = 0;
    wr_t        exp_q[$];
    wr_t        mon_e;
    logic [7:0] img[$];
    logic [7:0] ram [0:(1<<AW)-1];

    always @(negedge Clk) begin
        if (mem_we) begin
            nwrites++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0d data=%02h", mem_addr, mem_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (mem_addr !== mon_e.addr || mem_data !== mon_e.data) begin
                    errors++;
                    $display("FAIL write_order got addr=%0d data=%02h want addr=%0d data=%02h",
                             mem_addr, mem_data, mon_e.addr, mon_e.data);
                end
            end
            ram[mem_addr] = mem_data;
        end
    end

    task automatic pulse_start;
        @(negedge Clk);
        start = 1'b1;
        @(posedge Clk);
        #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit poke);
        int t = 0;
        @(negedge Clk);
        while (!byte_ready && t < 50) begin
            @(negedge Clk);
            t++;
        end
        if (!byte_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout byte=%02h byte_ready=%b want 1", b, byte_ready);
            return;
        end
        byte_valid = 1'b1;
        byte_in    = b;
        @(posedge Clk);
        #1 byte_valid = 1'b0;
        if (poke && gap > 0) start = 1'b1;
        repeat (gap) @(negedge Clk);
        start = 1'b0;
    endtask

    task automatic send_image(input int max_gap, input bit poke);
        int  n = img.size() / 4;
        int  g;
        wr_t w;
        send_byte(8'(n >> 8), 0, 1'b0);
        send_byte(8'(n), 0, 1'b0);
        for (int i = 0; i < img.size(); i++) begin
            w.addr = AW'(i);
            w.data = img[i];
            exp_q.push_back(w);
            g = (max_gap > 0 && i != img.size() - 1) ? int'($urandom_range(1, max_gap)) : 0;
            send_byte(img[i], g, poke);
        end
    endtask

    task automatic test_release(input int n_hi, input string name);
        for (int k = 0; k < n_hi; k++) begin
            @(negedge Clk);
            checks++;
            if (cpu_reset !== 1'b1 || done !== 1'b0 || byte_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s_hold cyc=%0d cpu_reset=%b done=%b ready=%b want 1/0/0",
                         name, k, cpu_reset, done, byte_ready);
            end
        end
        @(negedge Clk);
        checks++;
        if (cpu_reset !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL %s_release cpu_reset=%b done=%b want 0/1", name, cpu_reset, done);
        end
    endtask

    task automatic check_image(input string name, input int wl, input int nw, input int nw0);
        checks++;
        if (words_loaded !== 16'(wl)) begin
            errors++;
            $display("FAIL %s_words got %0d want %0d", name, words_loaded, wl);
        end
        checks++;
        if (nwrites - nw0 !== nw || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_write_count got %0d pending %0d want %0d pending 0",
                     name, nwrites - nw0, exp_q.size(), nw);
        end
        for (int i = 0; i < img.size(); i++) begin
            checks++;
            if (ram[i] !== img[i]) begin
                errors++;
                $display("FAIL %s_ram[%0d] got %02h want %02h", name, i, ram[i], img[i]);
            end
        end
    endtask

    task automatic check_reset_vals(input string name);
        checks++;
        if (cpu_reset !== 1'b1 || byte_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 ||
            mem_data !== 8'h00 || done !== 1'b0 || error !== 1'b0 || words_loaded !== 16'h0) begin
            errors++;
            $display("FAIL %s rst=%b rdy=%b we=%b addr=%0d data=%02h done=%b err=%b wl=%0d want 1 0 0 0 00 0 0 0",
                     name, cpu_reset, byte_ready, mem_we, mem_addr, mem_data, done, error, words_loaded);
        end
    endtask

    task automatic test_reset;
        RESET_n = 1'b0;
        #12;
        check_reset_vals("reset_state");
        @(negedge Clk);
        RESET_n = 1'b1;
        repeat (2) @(negedge Clk);
        check_reset_vals("idle_after_reset");
    endtask

    task automatic test_load3;
        int nw0 = nwrites;
        img = '{8'h82, 8'h10, 8'h20, 8'h05, 8'hC2, 8'h00, 8'h60, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
        pulse_start();
        send_image(0, 1'b0);
        test_release(3, "load3");
        check_image("load3", 3, 12, nw0);
    endtask

    task automatic test_backpressure;
        int nw0 = nwrites;
        for (int i = 0; i < 12; i++) ram[i] = 8'h00;
        pulse_start();
        send_image(3, 1'b1);
        test_release(3, "gaps");
        check_image("gaps", 3, 12, nw0);
    endtask

    task automatic test_zero;
        int nw0 = nwrites;
        img.delete();
        pulse_start();
        send_image(0, 1'b0);
        test_release(2, "zero");
        check_image("zero", 0, 0, nw0);
    endtask

    task automatic test_oversize;
        pulse_start();
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h81, 0, 1'b0);
        @(negedge Clk);
        checks++;
        if (error !== 1'b1 || byte_ready !== 1'b0 || cpu_reset !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL oversize_err err=%b rdy=%b rst=%b done=%b want 1 0 1 0",
                     error, byte_ready, cpu_reset, done);
        end
        byte_valid = 1'b1;
        byte_in    = 8'h5A;
        repeat (3) begin
            @(negedge Clk);
            checks++;
            if (byte_ready !== 1'b0 || mem_we !== 1'b0 || error !== 1'b1) begin
                errors++;
                $display("FAIL oversize_hold rdy=%b we=%b err=%b want 0 0 1", byte_ready, mem_we, error);
            end
        end
        byte_valid = 1'b0;
        pulse_start();
        checks++;
        if (error !== 1'b0 || byte_ready !== 1'b1 || cpu_reset !== 1'b1) begin
            errors++;
            $display("FAIL oversize_restart err=%b rdy=%b rst=%b want 0 1 1", error, byte_ready, cpu_reset);
        end
    endtask

    task automatic test_reset_mid;
        wr_t w;
        int  nw0;
        // Already in HDR_HI after the oversize restart.
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h02, 0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            w.addr = AW'(i);
            w.data = 8'h11 * 8'(i + 1);
            exp_q.push_back(w);
            send_byte(w.data, 0, 1'b0);
        end
        @(negedge Clk);
        #2 RESET_n = 1'b0;
        #1 check_reset_vals("mid_reset_async");
        repeat (3) begin
            @(negedge Clk);
            checks++;
            if (mem_we !== 1'b0 || byte_ready !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_quiet we=%b rdy=%b want 0 0", mem_we, byte_ready);
            end
        end
        #2 RESET_n = 1'b1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL mid_reset_writes pending %0d want 0", exp_q.size());
        end
        nw0 = nwrites;
        img = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        pulse_start();
        send_image(0, 1'b0);
        test_release(3, "after_reset");
        check_image("after_reset", 1, 4, nw0);
    endtask

    task automatic test_reload;
        int nw0 = nwrites;
        pulse_start();
        checks++;
        if (cpu_reset !== 1'b1 || done !== 1'b0 || words_loaded !== 16'h0) begin
            errors++;
            $display("FAIL reload_start rst=%b done=%b wl=%0d want 1 0 0", cpu_reset, done, words_loaded);
        end
        img = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB5, 8'hB6, 8'hB7, 8'hB8};
        send_image(0, 1'b0);
        test_release(3, "reload");
        check_image("reload", 2, 8, nw0);
    endtask

    initial begin
        test_reset();
        test_load3();
        test_backpressure();
        test_zero();
        test_oversize();
        test_reset_mid();
        test_reload();
        repeat (3) @(negedge Clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout time=%0t limit=500000", $time);
        $fatal(1, "watchdog");
    end
endmodule
